// File: rtl/prog_loader.sv
// prog_loader: fills instruction memory from a host byte stream
// (16-bit little-endian word count, little-endian instruction words, then an
// XOR checksum byte) and releases the CPU through `start` only after a load
// whose checksum matched.
module prog_loader #(
    parameter int INST_DATA_WIDTH = 32,
    parameter int INST_ADDR_WIDTH = 10,
    parameter int MAX_WORDS       = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_req,
    input  logic                       s_valid,
    input  logic [7:0]                 s_data,
    output logic                       s_ready,
    output logic                       imem_wen,
    output logic [INST_ADDR_WIDTH-1:0] imem_waddr,
    output logic [INST_DATA_WIDTH-1:0] imem_wdata,
    output logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [INST_ADDR_WIDTH:0]   words_loaded
);

    localparam int IAW = INST_ADDR_WIDTH;
    localparam int IDW = INST_DATA_WIDTH;
    // Count is compared one bit wider so a 16-bit N can never alias the limit.
    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_lo_q, cnt_lo_d;
    logic [IAW-1:0]   n_last_q, n_last_d;      // index of the final word (N-1)
    logic [IDW-1:0]   shift_q, shift_d;        // word being assembled, LSB byte first
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [IAW-1:0]   word_idx_q, word_idx_d;
    logic [7:0]       csum_q, csum_d;
    logic             imem_wen_q, imem_wen_d;
    logic [IAW-1:0]   imem_waddr_q, imem_waddr_d;
    logic [IDW-1:0]   imem_wdata_q, imem_wdata_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [IAW:0]     words_loaded_q, words_loaded_d;

    logic             in_load;
    logic             accept;
    logic [15:0]      n_full;
    logic [IDW-1:0]   shift_next;

    // The stream is only open while a load is actually being parsed.
    assign in_load    = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CHK);
    assign accept     = s_valid && in_load;
    assign n_full     = {s_data, cnt_lo_q};
    assign shift_next = {s_data, shift_q[IDW-1:8]};

    // Next-state and next-output computation for the load FSM.
    always_comb begin
        state_d        = state_q;
        cnt_lo_d       = cnt_lo_q;
        n_last_d       = n_last_q;
        shift_d        = shift_q;
        byte_idx_d     = byte_idx_q;
        word_idx_d     = word_idx_q;
        csum_d         = csum_q;
        imem_wen_d     = 1'b0;
        imem_waddr_d   = imem_waddr_q;
        imem_wdata_d   = imem_wdata_q;
        start_d        = start_q;
        done_d         = done_q;
        err_d          = err_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_req) begin
                    state_d        = S_CNT_LO;
                    start_d        = 1'b0;
                    done_d         = 1'b0;
                    err_d          = 1'b0;
                    words_loaded_d = '0;
                    csum_d         = '0;
                    word_idx_d     = '0;
                    byte_idx_d     = '0;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    cnt_lo_d = s_data;
                    csum_d   = csum_q ^ s_data;
                    state_d  = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    csum_d = csum_q ^ s_data;
                    if ((n_full == 16'd0) || ({1'b0, n_full} > MAX_N)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        n_last_d = IAW'(n_full - 16'd1);
                        state_d  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ s_data;
                    shift_d    = shift_next;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        imem_wen_d     = 1'b1;
                        imem_waddr_d   = word_idx_q;
                        imem_wdata_d   = shift_next;
                        words_loaded_d = words_loaded_q + (IAW+1)'(1);
                        if (word_idx_q == n_last_q) begin
                            state_d = S_CHK;
                        end else begin
                            word_idx_d = word_idx_q + IAW'(1);
                        end
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    if (s_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        start_d = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any partial load at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_lo_q       <= '0;
            n_last_q       <= '0;
            shift_q        <= '0;
            byte_idx_q     <= '0;
            word_idx_q     <= '0;
            csum_q         <= '0;
            imem_wen_q     <= 1'b0;
            imem_waddr_q   <= '0;
            imem_wdata_q   <= '0;
            start_q        <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_lo_q       <= cnt_lo_d;
            n_last_q       <= n_last_d;
            shift_q        <= shift_d;
            byte_idx_q     <= byte_idx_d;
            word_idx_q     <= word_idx_d;
            csum_q         <= csum_d;
            imem_wen_q     <= imem_wen_d;
            imem_waddr_q   <= imem_waddr_d;
            imem_wdata_q   <= imem_wdata_d;
            start_q        <= start_d;
            done_q         <= done_d;
            err_q          <= err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign s_ready      = in_load;
    assign busy         = in_load;
    assign imem_wen     = imem_wen_q;
    assign imem_waddr   = imem_waddr_q;
    assign imem_wdata   = imem_wdata_q;
    assign start        = start_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: byte-stream loads with good and bad
// checksums, illegal counts, stream gaps, ignored load_req and mid-load reset.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        imem_wen;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [10:0] words_loaded;

    int          checks = 0;
    int          errors = 0;
    int          wen_cnt = 0;
    int          wen_base;
    bit          gap_en = 1'b0;
    logic [31:0] tb_mem [0:1023];

    prog_loader #(
        .INST_DATA_WIDTH(32),
        .INST_ADDR_WIDTH(10),
        .MAX_WORDS      (1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_req    (load_req),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .imem_wen    (imem_wen),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Capture every IMEM write in mid-cycle so the stored image is the DUT's.
    always @(negedge clk) begin
        if (imem_wen === 1'b1) begin
            wen_cnt = wen_cnt + 1;
            tb_mem[imem_waddr] = imem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte and return #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        if (gap_en && ($urandom_range(1) == 1)) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (s_ready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Send one word LSB first and check the write pulse that follows the 4th byte.
    task automatic send_word(input logic [31:0] w, input logic [9:0] idx);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
        end
        chk("wen_after_word", {31'd0, imem_wen}, 32'd1);
        chk("waddr", {22'd0, imem_waddr}, {22'd0, idx});
        chk("wdata", imem_wdata, w);
    endtask

    task automatic pulse_load;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic stream_end;
        s_valid = 1'b0;
        s_data  = 8'h00;
    endtask

    initial begin
        rst      = 1'b1;
        load_req = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: everything quiet.
        repeat (10) @(posedge clk);
        #1;
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_words", {21'd0, words_loaded}, 32'd0);
        chk("rst_waddr", {22'd0, imem_waddr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_wen_cnt", wen_cnt, 32'd0);
        $display("txn reset/idle: checked");

        // Good 2-word load; checksum = 02^00^13^00^10^00^23^20^01^00 = 03.
        pulse_load();
        chk("load_busy", {31'd0, busy}, 32'd1);
        chk("load_ready", {31'd0, s_ready}, 32'd1);
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h00100013, 10'd0);
        chk("words_1", {21'd0, words_loaded}, 32'd1);
        send_word(32'h00012023, 10'd1);
        chk("words_2", {21'd0, words_loaded}, 32'd2);
        send_byte(8'h03);
        chk("good_done", {31'd0, done}, 32'd1);
        chk("good_start", {31'd0, start}, 32'd1);
        chk("good_err", {31'd0, err}, 32'd0);
        chk("good_busy", {31'd0, busy}, 32'd0);
        chk("good_words", {21'd0, words_loaded}, 32'd2);
        chk("good_wen_cnt", wen_cnt, 32'd2);
        chk("good_mem0", tb_mem[0], 32'h00100013);
        chk("good_mem1", tb_mem[1], 32'h00012023);
        // s_valid held high in DONE: nothing consumed, status held.
        s_data = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold_ready", {31'd0, s_ready}, 32'd0);
        chk("done_hold_done", {31'd0, done}, 32'd1);
        chk("done_hold_words", {21'd0, words_loaded}, 32'd2);
        stream_end();
        $display("txn good 2-word load: done=%0b start=%0b words=%0d", done, start, words_loaded);

        // Same stream, bad checksum.
        pulse_load();
        chk("reload_start_clr", {31'd0, start}, 32'd0);
        chk("reload_done_clr", {31'd0, done}, 32'd0);
        chk("reload_words_clr", {21'd0, words_loaded}, 32'd0);
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h00100013, 10'd0);
        send_word(32'h00012023, 10'd1);
        send_byte(8'h00);
        stream_end();
        chk("bad_err", {31'd0, err}, 32'd1);
        chk("bad_start", {31'd0, start}, 32'd0);
        chk("bad_done", {31'd0, done}, 32'd0);
        chk("bad_wen_cnt", wen_cnt, 32'd4);
        $display("txn bad checksum: err=%0b start=%0b", err, start);

        // Count N=0.
        wen_base = wen_cnt;
        pulse_load();
        send_byte(8'h00); send_byte(8'h00);
        stream_end();
        chk("n0_err", {31'd0, err}, 32'd1);
        chk("n0_ready", {31'd0, s_ready}, 32'd0);
        chk("n0_busy", {31'd0, busy}, 32'd0);
        // Count N=1025 (> MAX_WORDS).
        pulse_load();
        send_byte(8'h01); send_byte(8'h04);
        s_data = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        stream_end();
        chk("n1025_err", {31'd0, err}, 32'd1);
        chk("n1025_ready", {31'd0, s_ready}, 32'd0);
        chk("bad_count_wen", wen_cnt, wen_base);
        $display("txn illegal counts: err=%0b", err);

        // Boundary count N=1024 is legal: first word lands and load stays busy.
        pulse_load();
        send_byte(8'h00); send_byte(8'h04);
        chk("n1024_busy", {31'd0, busy}, 32'd1);
        chk("n1024_err", {31'd0, err}, 32'd0);
        send_word(32'hCAFEF00D, 10'd0);
        stream_end();
        $display("txn count 1024 accepted");

        // Abandon it with reset, then a 4-word load with random gaps (csum 2F).
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        gap_en = 1'b1;
        wen_base = wen_cnt;
        pulse_load();
        send_byte(8'h04); send_byte(8'h00);
        send_word(32'hDEADBEEF, 10'd0);
        s_valid = 1'b0;
        pulse_load();
        chk("ign_load_busy", {31'd0, busy}, 32'd1);
        chk("ign_load_words", {21'd0, words_loaded}, 32'd1);
        send_word(32'h12345678, 10'd1);
        send_word(32'hA5A55A5A, 10'd2);
        send_word(32'h00000001, 10'd3);
        send_byte(8'h2F);
        stream_end();
        gap_en = 1'b0;
        chk("gap_done", {31'd0, done}, 32'd1);
        chk("gap_words", {21'd0, words_loaded}, 32'd4);
        chk("gap_wen_cnt", wen_cnt - wen_base, 32'd4);
        chk("gap_mem0", tb_mem[0], 32'hDEADBEEF);
        chk("gap_mem1", tb_mem[1], 32'h12345678);
        chk("gap_mem2", tb_mem[2], 32'hA5A55A5A);
        chk("gap_mem3", tb_mem[3], 32'h00000001);
        $display("txn gapped 4-word load: done=%0b words=%0d", done, words_loaded);

        // Reset after 6 data bytes.
        pulse_load();
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h44332211, 10'd0);
        send_byte(8'h55); send_byte(8'h66);
        stream_end();
        wen_base = wen_cnt;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, s_ready}, 32'd0);
        chk("mid_rst_words", {21'd0, words_loaded}, 32'd0);
        chk("mid_rst_wen", {31'd0, imem_wen}, 32'd0);
        chk("mid_rst_wdata", imem_wdata, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_write", wen_cnt, wen_base);
        chk("mid_rst_idle_ready", {31'd0, s_ready}, 32'd0);
        // 1-word load after reset; checksum = 01^00^78^56^34^12 = 09.
        pulse_load();
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h12345678, 10'd0);
        send_byte(8'h09);
        stream_end();
        chk("post_rst_done", {31'd0, done}, 32'd1);
        chk("post_rst_start", {31'd0, start}, 32'd1);
        chk("post_rst_words", {21'd0, words_loaded}, 32'd1);
        chk("post_rst_mem0", tb_mem[0], 32'h12345678);
        $display("txn reset mid-load then 1-word load: done=%0b", done);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
